sha_msg_schedule: RTL

- Upstream feeder of the SHA-256 round pipeline: the per-round W/K source for sha_round.
- Accepts one 512-bit message block through a valid/ready handshake.
- Emits the 64 message-schedule words W[0..63] with the matching round constant K[0..63], one pair per accepted output beat.
- Uses a 16-word sliding window, so only one new W word is computed per beat.

---
 rtl/sha_pkg.sv | 39 +++
 rtl/sha_msg_schedule_if.sv | 25 ++
 rtl/sha_msg_sigma.sv | 12 +
 rtl/sha_msg_schedule.sv | 82 ++++++++
 4 files changed

// File: rtl/sha_pkg.sv
// sha_pkg: shared SHA-256 types, schedule FSM states and the K round-constant table
package sha_pkg;
    typedef logic [31:0] sched_word_t;

    typedef struct packed {
        sched_word_t a;
        sched_word_t b;
        sched_word_t c;
        sched_word_t d;
        sched_word_t e;
        sched_word_t f;
        sched_word_t g;
        sched_word_t h;
    } hash_state_t;

    typedef enum logic {
        SCHED_IDLE,
        SCHED_RUN
    } sched_state_t;

    localparam sched_word_t K_TABLE [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
endpackage

// File: rtl/sha_msg_schedule_if.sv
// sha_msg_schedule_if: block-in / W,K-out handshake bundle of the message scheduler
interface sha_msg_schedule_if;
    import sha_pkg::*;

    logic          blk_valid;
    logic          blk_ready;
    logic [511:0]  blk;
    logic          w_valid;
    logic          w_ready;
    sched_word_t   W;
    sched_word_t   K;
    logic [5:0]    t_idx;
    logic          first;
    logic          last;

    modport slave (
        input  blk_valid, blk, w_ready,
        output blk_ready, w_valid, W, K, t_idx, first, last
    );

    modport master (
        output blk_valid, blk, w_ready,
        input  blk_ready, w_valid, W, K, t_idx, first, last
    );
endinterface

// File: rtl/sha_msg_sigma.sv
// sha_msg_sigma: SHA-256 small sigma functions s0 and s1 for the schedule update
module sha_msg_sigma
    import sha_pkg::*;
(
    input  sched_word_t s0_x_i,
    input  sched_word_t s1_x_i,
    output sched_word_t s0_o,
    output sched_word_t s1_o
);
    assign s0_o = {s0_x_i[6:0], s0_x_i[31:7]} ^ {s0_x_i[17:0], s0_x_i[31:18]} ^ (s0_x_i >> 3);
    assign s1_o = {s1_x_i[16:0], s1_x_i[31:17]} ^ {s1_x_i[18:0], s1_x_i[31:19]} ^ (s1_x_i >> 10);
endmodule

// File: rtl/sha_msg_schedule.sv
// sha_msg_schedule: streams W[t]/K[t] for one 512-bit block from a 16-word sliding window;
// define SHA_SCHED_BACKTOBACK_EN to accept the next block on the last-word beat (no bubble)
module sha_msg_schedule
    import sha_pkg::*;
#(
    parameter int ROUNDS = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sha_msg_schedule_if.slave     bus
);
    localparam logic [5:0] T_LAST = 6'(ROUNDS - 1);

    sched_state_t state_q;
    sched_word_t  win_q [16];
    logic [5:0]   t_q;
    logic         w_valid_q;
    logic         first_q;
    logic         last_q;
    sched_word_t  s0;
    sched_word_t  s1;
    sched_word_t  win_new_d;
    logic         blk_hs;
    logic         w_hs;

    sha_msg_sigma u_sigma (
        .s0_x_i (win_q[1]),
        .s1_x_i (win_q[14]),
        .s0_o   (s0),
        .s1_o   (s1)
    );

    assign win_new_d = s1 + win_q[9] + s0 + win_q[0];

`ifdef SHA_SCHED_BACKTOBACK_EN
    // last_q is only ever set in RUN, so this opens the input exactly on the final beat
    assign bus.blk_ready = (state_q == SCHED_IDLE) || (last_q && bus.w_ready);
`else
    assign bus.blk_ready = (state_q == SCHED_IDLE);
`endif

    assign blk_hs    = bus.blk_valid && bus.blk_ready;
    assign w_hs      = w_valid_q && bus.w_ready;
    assign bus.w_valid = w_valid_q;
    assign bus.W     = win_q[0];
    assign bus.K     = K_TABLE[t_q];
    assign bus.t_idx = t_q;
    assign bus.first = first_q;
    assign bus.last  = last_q;

    // schedule FSM: load on block accept, slide the window per taken beat, return to IDLE after the last
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SCHED_IDLE;
            t_q       <= '0;
            w_valid_q <= 1'b0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
            for (int i = 0; i < 16; i++) win_q[i] <= '0;
        end else if (blk_hs) begin
            state_q   <= SCHED_RUN;
            t_q       <= '0;
            w_valid_q <= 1'b1;
            first_q   <= 1'b1;
            last_q    <= 1'b0;
            for (int i = 0; i < 16; i++) win_q[i] <= bus.blk[511 - 32*i -: 32];
        end else if (w_hs) begin
            if (last_q) begin
                state_q   <= SCHED_IDLE;
                w_valid_q <= 1'b0;
                first_q   <= 1'b0;
                last_q    <= 1'b0;
            end else begin
                for (int i = 0; i < 15; i++) win_q[i] <= win_q[i+1];
                win_q[15] <= win_new_d;
                t_q       <= t_q + 6'd1;
                first_q   <= 1'b0;
                last_q    <= (t_q + 6'd1) == T_LAST;
            end
        end
    end
endmodule
